// File: rtl/dmem_ctrl.sv
// Data memory controller: single-outstanding request, programmable wait states,
// byte-lane alignment of store strobes/data and load data, out-of-range detection.
module dmem_ctrl #(
   parameter int unsigned DEPTH_WORDS = 1024,
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        i_clk,
   input  logic        i_rst,
   input  logic        i_req,
   input  logic        i_we,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_wdata,
   input  logic [3:0]  i_wstrb,
   output logic        o_ready,
   output logic        o_rvalid,
   output logic [31:0] o_rdata,
   output logic        o_err,
   output logic        o_busy
);

   localparam int unsigned XLEN       = 32;
   localparam int unsigned BYTE_WIDTH = 8;
   localparam int unsigned NBYTES     = XLEN / BYTE_WIDTH;
   localparam int unsigned AW         = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

   state_t            state_q;
   logic [3:0]        cnt_q;
   logic [XLEN-1:0]   addr_q;
   logic              we_q;
   logic [XLEN-1:0]   wdata_q;
   logic [NBYTES-1:0] wstrb_q;
   logic [XLEN-1:0]   rdata_q;
   logic              err_q;

   // Array contents are deliberately never reset.
   logic [XLEN-1:0]   mem [DEPTH_WORDS];

   logic [1:0]        lane;
   logic [4:0]        shamt;
   logic [AW-1:0]     idx;
   logic              in_range;
   logic [NBYTES-1:0] eff_strb;
   logic [XLEN-1:0]   eff_data;
   logic [XLEN-1:0]   rd_word;
   logic              access;

   // Lane alignment and address decode of the latched request
   always_comb begin
      lane     = addr_q[1:0];
      shamt    = {lane, 3'b000};
      idx      = addr_q[AW+1:2];
      in_range = (addr_q >> (AW + 2)) == '0;
      // Strobe bits shifted past the top lane fall off the 4-bit result.
      eff_strb = wstrb_q << lane;
      eff_data = wdata_q << shamt;
      rd_word  = mem[idx] >> shamt;
      access   = (state_q == StWait) && (cnt_q == '0);
   end

   // Control FSM with registered response data/error
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= StIdle;
         cnt_q   <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         wstrb_q <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         case (state_q)
            StIdle: begin
               if (i_req) begin
                  addr_q  <= i_addr;
                  we_q    <= i_we;
                  wdata_q <= i_wdata;
                  wstrb_q <= i_wstrb;
                  cnt_q   <= 4'(WAIT_CYCLES);
                  state_q <= StWait;
               end
            end
            StWait: begin
               if (cnt_q != '0) begin
                  cnt_q <= cnt_q - 4'd1;
               end else begin
                  err_q   <= !in_range;
                  rdata_q <= (!we_q && in_range) ? rd_word : '0;
                  state_q <= StResp;
               end
            end
            StResp: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

   // Byte-masked array write on the access edge; reset forces IDLE so aborted stores never land
   always_ff @(posedge i_clk) begin
      if (access && we_q && in_range) begin
         for (int b = 0; b < NBYTES; b++) begin
            if (eff_strb[b]) begin
               mem[idx][BYTE_WIDTH*b +: BYTE_WIDTH] <= eff_data[BYTE_WIDTH*b +: BYTE_WIDTH];
            end
         end
      end
   end

   // Handshake outputs decoded from the state register only
   always_comb begin
      o_ready  = (state_q == StIdle);
      o_busy   = (state_q != StIdle);
      o_rvalid = (state_q == StResp);
      o_rdata  = rdata_q;
      o_err    = err_q;
   end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: table of directed transactions on a WAIT_CYCLES=1
// instance plus hand sequences for reset abort, busy-ignore and back-to-back on WAIT_CYCLES=0.
module tb_dmem_ctrl;

   localparam int unsigned DEPTH = 1024;
   localparam int unsigned WAITS = 1;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        req, we;
   logic [31:0] addr, wdata;
   logic [3:0]  wstrb;
   logic        ready, rvalid, err, busy;
   logic [31:0] rdata;

   logic        req_z;
   logic        ready_z, rvalid_z, err_z, busy_z;
   logic [31:0] rdata_z;

   dmem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITS)) dut (
      .i_clk(clk), .i_rst(rst), .i_req(req), .i_we(we), .i_addr(addr),
      .i_wdata(wdata), .i_wstrb(wstrb), .o_ready(ready), .o_rvalid(rvalid),
      .o_rdata(rdata), .o_err(err), .o_busy(busy)
   );

   dmem_ctrl #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0)) dut_z (
      .i_clk(clk), .i_rst(rst), .i_req(req_z), .i_we(1'b1), .i_addr(32'h0),
      .i_wdata(32'h0000_0001), .i_wstrb(4'hf), .o_ready(ready_z), .o_rvalid(rvalid_z),
      .o_rdata(rdata_z), .o_err(err_z), .o_busy(busy_z)
   );

   typedef struct {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [3:0]  wstrb;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   vec_t vecs [$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   // One request through the WAIT_CYCLES=1 instance; returns latency in negedges and busy count.
   task automatic run_txn(input logic t_we, input logic [31:0] t_addr, input logic [31:0] t_wdata,
                          input logic [3:0] t_wstrb, output logic [31:0] r_data,
                          output logic r_err, output int lat, output int busy_cyc);
      @(negedge clk);
      check("ready_before_req", 32'(ready), 32'd1);
      req = 1'b1; we = t_we; addr = t_addr; wdata = t_wdata; wstrb = t_wstrb;
      @(posedge clk);
      #1 req = 1'b0;
      lat = 0;
      busy_cyc = 0;
      do begin
         @(negedge clk);
         lat++;
         if (busy) busy_cyc++;
      end while (!rvalid && lat < 40);
      r_data = rdata;
      r_err  = err;
   endtask

   initial begin
      logic [31:0] got;
      logic        got_err;
      int          lat, bcyc, bad, pulses;

      rst = 1'b1; req = 1'b0; we = 1'b0; addr = '0; wdata = '0; wstrb = '0; req_z = 1'b0;

      vecs.push_back('{1'b1, 32'h10,   32'hDEADBEEF, 4'hf, 32'h0,        1'b0});
      vecs.push_back('{1'b0, 32'h10,   32'h0,        4'hf, 32'hDEADBEEF, 1'b0});
      vecs.push_back('{1'b1, 32'h13,   32'h000000AA, 4'h1, 32'h0,        1'b0});
      vecs.push_back('{1'b0, 32'h10,   32'h0,        4'hf, 32'hAAADBEEF, 1'b0});
      vecs.push_back('{1'b0, 32'h13,   32'h0,        4'hf, 32'h000000AA, 1'b0});
      vecs.push_back('{1'b1, 32'h13,   32'h00001234, 4'h3, 32'h0,        1'b0});
      vecs.push_back('{1'b0, 32'h10,   32'h0,        4'hf, 32'h34ADBEEF, 1'b0});
      vecs.push_back('{1'b1, 32'h11,   32'h00005566, 4'h3, 32'h0,        1'b0});
      vecs.push_back('{1'b0, 32'h10,   32'h0,        4'hf, 32'h345566EF, 1'b0});
      vecs.push_back('{1'b0, 32'h12,   32'hFFFFFFFF, 4'h0, 32'h00003455, 1'b0});
      vecs.push_back('{1'b1, 32'h0,    32'h11223344, 4'hf, 32'h0,        1'b0});
      vecs.push_back('{1'b0, 32'h1000, 32'h0,        4'hf, 32'h0,        1'b1});
      vecs.push_back('{1'b1, 32'h1000, 32'h55555555, 4'hf, 32'h0,        1'b1});
      vecs.push_back('{1'b0, 32'h0,    32'h0,        4'hf, 32'h11223344, 1'b0});
      vecs.push_back('{1'b0, 32'h1003, 32'h0,        4'hf, 32'h0,        1'b1});
      vecs.push_back('{1'b1, 32'hFFC,  32'hA5A5A5A5, 4'hf, 32'h0,        1'b0});
      vecs.push_back('{1'b0, 32'hFFF,  32'h0,        4'hf, 32'h000000A5, 1'b0});
      vecs.push_back('{1'b1, 32'h20,   32'hCAFEF00D, 4'hf, 32'h0,        1'b0});
      vecs.push_back('{1'b1, 32'h22,   32'h0000BEEF, 4'h3, 32'h0,        1'b0});
      vecs.push_back('{1'b0, 32'h21,   32'h0,        4'hf, 32'h00BEEFF0, 1'b0});
      vecs.push_back('{1'b1, 32'h20,   32'hFFFFFFFF, 4'h0, 32'h0,        1'b0});
      vecs.push_back('{1'b0, 32'h20,   32'h0,        4'hf, 32'hBEEFF00D, 1'b0});

      // Reset state
      #2;
      check("rst_ready",  32'(ready),  32'd1);
      check("rst_busy",   32'(busy),   32'd0);
      check("rst_rvalid", 32'(rvalid), 32'd0);
      check("rst_err",    32'(err),    32'd0);
      check("rst_rdata",  rdata,       32'h0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      // Table-driven transactions
      foreach (vecs[i]) begin
         run_txn(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].wstrb, got, got_err, lat, bcyc);
         check($sformatf("v%0d_latency", i), 32'(lat), 32'(WAITS + 2));
         check($sformatf("v%0d_busy_cycles", i), 32'(bcyc), 32'(WAITS + 2));
         check($sformatf("v%0d_rdata", i), got, vecs[i].exp_rdata);
         check($sformatf("v%0d_err", i), 32'(got_err), 32'(vecs[i].exp_err));
         @(negedge clk);
         check($sformatf("v%0d_rvalid_drop", i), 32'(rvalid), 32'd0);
         check($sformatf("v%0d_rdata_hold", i), rdata, vecs[i].exp_rdata);
      end

      // Reset during WAIT of a store to word 8 aborts it
      @(negedge clk);
      req = 1'b1; we = 1'b1; addr = 32'h20; wdata = 32'h12345678; wstrb = 4'hf;
      @(posedge clk);
      #1 req = 1'b0;
      check("abort_in_wait_busy", 32'(busy), 32'd1);
      #1 rst = 1'b1;
      #1;
      check("abort_ready",  32'(ready),  32'd1);
      check("abort_busy",   32'(busy),   32'd0);
      check("abort_rvalid", 32'(rvalid), 32'd0);
      check("abort_err",    32'(err),    32'd0);
      check("abort_rdata",  rdata,       32'h0);
      bad = 0;
      repeat (3) begin
         @(negedge clk);
         if (rvalid) bad++;
      end
      // Request already present on the first edge after reset release
      req = 1'b1; we = 1'b0; addr = 32'h20; wstrb = 4'h0;
      rst = 1'b0;
      @(posedge clk);
      #1 req = 1'b0;
      lat = 0;
      do begin
         @(negedge clk);
         lat++;
      end while (!rvalid && lat < 40);
      check("abort_no_rvalid_in_reset", 32'(bad), 32'd0);
      check("post_reset_accept_latency", 32'(lat), 32'(WAITS + 2));
      check("abort_word8_unchanged", rdata, 32'hBEEFF00D);

      // Requests while busy are ignored: hold req high with a store payload after acceptance
      @(negedge clk);
      @(negedge clk);
      req = 1'b1; we = 1'b0; addr = 32'h10; wdata = 32'h0; wstrb = 4'hf;
      @(posedge clk);
      #1 we = 1'b1;
      bad = 0;
      repeat (2) begin
         @(negedge clk);
         if (ready || rvalid) bad++;
      end
      @(negedge clk);
      check("busy_ignore_ready_low", 32'(bad), 32'd0);
      check("busy_ignore_rvalid", 32'(rvalid), 32'd1);
      check("busy_ignore_rdata", rdata, 32'h345566EF);
      req = 1'b0;
      run_txn(1'b0, 32'h10, 32'h0, 4'hf, got, got_err, lat, bcyc);
      check("busy_ignore_no_write", got, 32'h345566EF);

      // WAIT_CYCLES=0 with req held high: one acceptance every three cycles
      @(negedge clk);
      req_z = 1'b1;
      bad = 0;
      pulses = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (rvalid_z) pulses++;
         if (rvalid_z !== ((i % 3) == 1)) bad++;
         if (ready_z !== ((i % 3) == 2)) bad++;
         if (busy_z !== ((i % 3) != 2)) bad++;
         if (rvalid_z && err_z) bad++;
      end
      req_z = 1'b0;
      check("b2b_pattern_errors", 32'(bad), 32'd0);
      check("b2b_pulse_count", 32'(pulses), 32'd10);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024: number of XLEN-bit words in the data array; must be a power of two.
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 1: extra access wait states, range 0..15.
REQ-003 The block SHALL have port i_clk, input, 1: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port i_rst, input, 1: reset, asynchronous and active-high.
REQ-005 The block SHALL have port i_req, input, 1: access request.
REQ-006 The block SHALL have port i_we, input, 1: 1 = store, 0 = load; driven from the store-enable output of the load-store unit.
REQ-007 The block SHALL have port i_addr, input, XLEN: byte offset into data memory, already rebased to 0.
REQ-008 The block SHALL have port i_wdata, input, XLEN: store data, low-lane aligned.
REQ-009 The block SHALL have port i_wstrb, input, XLEN/BYTE_WIDTH: byte strobe, low-lane aligned (0001, 0011 or 1111).
REQ-010 The block SHALL have port o_ready, output, 1: high when a request can be accepted.
REQ-011 The block SHALL have port o_rvalid, output, 1: one-cycle response strobe.
REQ-012 The block SHALL have port o_rdata, output, XLEN: load data, shifted to the low lane.
REQ-013 The block SHALL have port o_err, output, 1: the response is for an out-of-range address; valid only with o_rvalid.
REQ-014 The block SHALL have port o_busy, output, 1: stall request to the core.

Function
REQ-015 The block SHALL implement a state machine with states IDLE, WAIT and RESP, and a 4-bit wait counter.
REQ-016 o_ready SHALL be 1 only in IDLE, and o_busy SHALL equal (state != IDLE); both are decoded from the state register, not from inputs.
REQ-017 Acceptance SHALL occur on an edge where state = IDLE and i_req = 1: latch i_addr, i_we, i_wdata and i_wstrb, load counter = WAIT_CYCLES, and go to WAIT.
REQ-018 In WAIT with counter != 0, each edge SHALL decrement the counter.
REQ-019 In WAIT with counter = 0, the next edge SHALL perform the array access, register o_rdata/o_err, and go to RESP.
REQ-020 RESP SHALL assert o_rvalid for exactly one cycle; the next edge SHALL return to IDLE.
REQ-021 Latency SHALL be: accept at edge k gives o_rvalid high between edges k+WAIT_CYCLES+1 and k+WAIT_CYCLES+2.
REQ-022 Minimum request spacing SHALL be WAIT_CYCLES+3 cycles.
REQ-023 i_req while o_ready = 0 SHALL be ignored, with no queuing.
REQ-024 Lane alignment: lane = latched addr[1:0]; the effective strobe SHALL be (wstrb << lane) truncated to 4 bits, and the effective data SHALL be wdata << (8*lane); strobe bits shifted past bit 3 SHALL be discarded.
REQ-025 A write SHALL update only the bytes whose effective strobe bit is 1, at word index addr[log2(DEPTH_WORDS)+1:2].
REQ-026 A write with an effective strobe of 0000 SHALL leave the array unchanged and still produce a normal o_rvalid with o_err = 0.
REQ-027 A read SHALL set o_rdata = stored word >> (8*lane), zero-filled; i_wstrb SHALL be ignored on reads.
REQ-028 A write response SHALL drive o_rdata = 0.
REQ-029 An address with addr >= 4*DEPTH_WORDS SHALL be out of range: no array write, o_rdata = 0, and o_err = 1 in RESP.
REQ-030 o_rdata and o_err SHALL hold their values outside RESP until the next access; o_rvalid SHALL be 0 outside RESP.

Reset
REQ-031 Asserting i_rst SHALL immediately force state = IDLE, counter = 0, o_rvalid = 0, o_err = 0, o_rdata = 0, o_ready = 1 and o_busy = 0.
REQ-032 A reset during WAIT SHALL abort the pending access, and no array write SHALL occur.
REQ-033 Array contents SHALL NOT be reset.
REQ-034 A request present on the first edge after reset deasserts SHALL be accepted.

Verification
REQ-035 Scenario (WAIT_CYCLES=1): store word 0xDEADBEEF at addr 0x10 with strobe 1111, then load addr 0x10 -> o_rdata = 0xDEADBEEF, o_rvalid 2 cycles after acceptance, o_busy high for 3 cycles.
REQ-036 Scenario: store byte 0xAA at addr 0x13 (strobe 0001), then load word at addr 0x10 -> o_rdata = 0xAAADBEEF; load at addr 0x13 -> o_rdata = 0x000000AA.
REQ-037 Scenario: store half 0x1234 at addr 0x13 (strobe 0011) -> only byte 3 of word 4 is written (0x34); the upper byte is discarded.
REQ-038 Scenario: load at addr 4*DEPTH_WORDS -> o_rvalid = 1, o_err = 1, o_rdata = 0; a store there leaves the array unchanged.
REQ-039 Scenario: assert i_rst during WAIT of a store to addr 0x20 -> o_rvalid never pulses, and word 8 keeps its old value.
REQ-040 Scenario: hold i_req high continuously with WAIT_CYCLES=0 -> one acceptance every 3 cycles; requests during o_busy are not accepted.
